// File: rtl/seven_seg_scan_ctrl.sv
// Scan scheduler for an N-digit multiplexed 7-segment display.
// Each digit slot runs DEAD (anodes dark), then ON (PWM window), then OFF.
// A pending/active double buffer swaps only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned DEAD_CYCLES = 1000,
  parameter int unsigned ON_STEP     = 12375
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   load,
  output logic                   load_ready,
  input  logic                   blank_lz,
  input  logic [2:0]             bright,
  output logic [3:0]             bcd_out,
  output logic                   dp_out,
  output logic [NDIGITS-1:0]     anode,
  output logic                   frame_done
);

  localparam int unsigned SLOT_MAX = (DEAD_CYCLES > 8 * ON_STEP) ? DEAD_CYCLES : 8 * ON_STEP;
  localparam int unsigned CNT_W    = $clog2(SLOT_MAX + 1);
  localparam int unsigned IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON, S_OFF} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bright_q, bright_d;
  logic [4*NDIGITS-1:0] active_bcd_q, pend_bcd_q;
  logic [NDIGITS-1:0]   active_dp_q, pend_dp_q;
  logic                 pend_valid_q;

  logic                 slot_end;
  logic                 last_digit;
  logic [CNT_W-1:0]     dead_last, on_last, off_last;
  logic [NDIGITS-1:0]   blanked;
  logic                 zero_run;

  // Terminal counts of each phase; ON/OFF lengths follow the brightness held for this slot.
  assign dead_last  = CNT_W'(DEAD_CYCLES - 1);
  assign on_last    = CNT_W'(({29'd0, bright_q} + 32'd1) * ON_STEP - 32'd1);
  assign off_last   = CNT_W'((32'd7 - {29'd0, bright_q}) * ON_STEP - 32'd1);
  assign last_digit = (idx_q == IDX_W'(NDIGITS - 1));

  // Next-state logic: phase sequencing, slot counter, digit index, brightness capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bright_d = bright_q;
    slot_end = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_DEAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_DEAD: begin
          if (cnt_q == '0) bright_d = bright;
          if (cnt_q == dead_last) begin
            state_d = S_ON;
            cnt_d   = '0;
          end
        end
        S_ON: begin
          if (cnt_q == on_last) begin
            if (bright_q == 3'd7) begin
              slot_end = 1'b1;
            end else begin
              state_d = S_OFF;
              cnt_d   = '0;
            end
          end
        end
        S_OFF: begin
          if (cnt_q == off_last) slot_end = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (slot_end) begin
      state_d = S_DEAD;
      cnt_d   = '0;
      idx_d   = last_digit ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign frame_done = slot_end && last_digit;
  assign load_ready = !pend_valid_q;

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      bright_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end

  // Double buffer: loads fill pending, frame boundary promotes pending to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: display buffers are reset so a fresh power-up shows zeros, not garbage.
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else if (frame_done && pend_valid_q) begin
      active_bcd_q <= pend_bcd_q;
      active_dp_q  <= pend_dp_q;
      pend_valid_q <= 1'b0;
    end else if (load && !pend_valid_q) begin
      pend_bcd_q   <= bcd_in;
      pend_dp_q    <= dp_in;
      pend_valid_q <= 1'b1;
    end
  end

  // Leading-zero mask: digit k blanks when it and all higher digits are zero; digit 0 never.
  always_comb begin
    blanked  = '0;
    zero_run = 1'b1;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (active_bcd_q[4*k +: 4] == 4'd0);
      blanked[k] = blank_lz && zero_run;
    end
  end

  // Display outputs: anode only in ON for an unblanked digit; dp gated by that anode.
  always_comb begin
    anode   = '0;
    bcd_out = active_bcd_q[4*idx_q +: 4];
    if (state_q == S_ON && !blanked[idx_q]) anode = NDIGITS'(1) << idx_q;
    dp_out  = active_dp_q[idx_q] && anode[idx_q];
  end

endmodule
